tri_eccerr_ctl: RTL

TRI_ECCERR_CTL -- requirements
Module: tri_eccerr_ctl

---
 rtl/trilib_pkg.sv | 19 +
 rtl/tri_eccerr_cnt.sv | 37 +++
 rtl/tri_eccerr_ctl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/trilib_pkg.sv
// Shared ECC-error control definitions: FSM encoding and
// SBE counter width/saturation helpers.
package trilib_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WBREQ = 1'b1;

  localparam int unsigned CNT_W = 8;

  localparam logic [CNT_W-1:0] CNT_SAT = 8'hFF;

  // Increment that sticks at the saturation value.
  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_SAT) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/tri_eccerr_cnt.sv
// Saturating SBE event counter; a clear in the same cycle as
// an increment leaves the count at one.
module tri_eccerr_cnt
  import trilib_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear takes priority, then the increment is applied.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? CNT_W'(1) : '0;
    end else if (inc_i) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tri_eccerr_ctl.sv
// ECC error controller: SBE counting, threshold and UE capture.
// Corrected write-back path enabled by TRI_ECC_WRITEBACK_EN.
module tri_eccerr_ctl
  import trilib_pkg::*;
#(
  parameter int REGSIZE = 64,
  parameter int ADDRW   = 8
) (
  input  logic               nclk,
  input  logic               rst_n,
  input  logic               rd_val,
  input  logic [ADDRW-1:0]   rd_addr,
  input  logic [REGSIZE-1:0] rd_corrd,
  input  logic               rd_sbe,
  input  logic               rd_ue,
  input  logic [7:0]         err_thresh,
  input  logic               err_clr,
  output logic               wb_val,
  input  logic               wb_rdy,
  output logic [ADDRW-1:0]   wb_addr,
  output logic [REGSIZE-1:0] wb_data,
  output logic               busy,
  output logic [7:0]         sbe_cnt,
  output logic               thresh_int,
  output logic               ue_int,
  output logic [ADDRW-1:0]   ue_addr,
  output logic               sbe_drop
);

  logic q_sbe;
  logic q_ue;

  // A UE masks any coincident SBE flag.
  assign q_sbe = rd_val & rd_sbe & ~rd_ue;
  assign q_ue  = rd_val & rd_ue;

  tri_eccerr_cnt u_cnt (
    .clk_i  (nclk),
    .rst_ni (rst_n),
    .clr_i  (err_clr),
    .inc_i  (q_sbe),
    .cnt_o  (sbe_cnt)
  );

  logic             thr_q;
  logic             thr_d;
  logic             ue_int_q;
  logic             ue_int_d;
  logic [ADDRW-1:0] ue_addr_q;
  logic [ADDRW-1:0] ue_addr_d;

  // Sticky threshold and first-UE capture, clear before event.
  always_comb begin
    thr_d     = thr_q;
    ue_int_d  = ue_int_q;
    ue_addr_d = ue_addr_q;
    if (err_clr) begin
      thr_d     = 1'b0;
      ue_int_d  = 1'b0;
      ue_addr_d = '0;
    end else if ((err_thresh != 8'd0)
                 && (sbe_cnt >= err_thresh)) begin
      thr_d = 1'b1;
    end
    if (q_ue && !ue_int_d) begin
      ue_int_d  = 1'b1;
      ue_addr_d = rd_addr;
    end
  end

  // Error status registers.
  always_ff @(posedge nclk) begin
    if (!rst_n) begin
      thr_q     <= 1'b0;
      ue_int_q  <= 1'b0;
      ue_addr_q <= '0;
    end else begin
      thr_q     <= thr_d;
      ue_int_q  <= ue_int_d;
      ue_addr_q <= ue_addr_d;
    end
  end

  assign thresh_int = thr_q;
  assign ue_int     = ue_int_q;
  assign ue_addr    = ue_addr_q;

`ifdef TRI_ECC_WRITEBACK_EN
  logic [0:0]         st_q;
  logic [0:0]         st_d;
  logic [ADDRW-1:0]   wba_q;
  logic [ADDRW-1:0]   wba_d;
  logic [REGSIZE-1:0] wbd_q;
  logic [REGSIZE-1:0] wbd_d;
  logic               drop_q;
  logic               drop_d;

  // Write-back request FSM; payload frozen until accepted.
  always_comb begin
    st_d   = st_q;
    wba_d  = wba_q;
    wbd_d  = wbd_q;
    drop_d = err_clr ? 1'b0 : drop_q;
    case (st_q)
      ST_IDLE: begin
        if (q_sbe) begin
          st_d  = ST_WBREQ;
          wba_d = rd_addr;
          wbd_d = rd_corrd;
        end
      end
      ST_WBREQ: begin
        if (q_sbe) begin
          drop_d = 1'b1;
        end
        if (wb_rdy) begin
          st_d = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // FSM and payload registers; reset abandons a pending request.
  always_ff @(posedge nclk) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      wba_q  <= '0;
      wbd_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      wba_q  <= wba_d;
      wbd_q  <= wbd_d;
      drop_q <= drop_d;
    end
  end

  assign wb_val   = (st_q == ST_WBREQ);
  assign busy     = (st_q == ST_WBREQ);
  assign wb_addr  = wba_q;
  assign wb_data  = wbd_q;
  assign sbe_drop = drop_q;
`else
  logic unused_wb;

  assign unused_wb = ^{wb_rdy, rd_corrd};

  assign wb_val   = 1'b0;
  assign busy     = 1'b0;
  assign wb_addr  = '0;
  assign wb_data  = '0;
  assign sbe_drop = 1'b0;
`endif

endmodule
